rotational_ensemble_sequencer: RTL and testbench

//  Drives one Y-channel output block of 4 pixels through the shared 3392x32 SRAM LUT and the rotational ensemble calculator.
//  - Accepts 4 LUT addresses, one per rotation (R, L, U, D).
//  - Issues 4 back-to-back single-port reads and unpacks each 32b word into 4 signed values.
//  - Presents the 16 values to the ensemble calculator, registers its 4 x 9b result and hands it downstream.

---
 rtl/rotational_ensemble_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rotational_ensemble_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotational_ensemble_sequencer.sv
// Reads the four rotation LUT words for one 4-pixel Y block and registers the ensemble result for downstream.
// Optional completed-block counter: define ROT_ENS_PERF_CNT_EN.
module rotational_ensemble_sequencer #(
  parameter int LUT_DEPTH = 3392,
  parameter int ADDR_W    = 12,
  parameter int RD_LAT    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [4*ADDR_W-1:0] in_addr_i,
  output logic                sram_ren_o,
  output logic [ADDR_W-1:0]   sram_addr_o,
  input  logic [31:0]         sram_q_i,
  output logic [43:0]         lut_R_o,
  output logic [43:0]         lut_L_o,
  output logic [43:0]         lut_U_o,
  output logic [43:0]         lut_D_o,
  input  logic [35:0]         ens_out_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [35:0]         out_pix_o,
  output logic                err_addr_o,
  output logic [15:0]         perf_blocks_o
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE0, ISSUE1, ISSUE2, ISSUE3, WAIT, CALC, HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
  logic [ADDR_W-1:0]  sramAddr_q;
  logic [ADDR_W-1:0]  nextAddr_q [3];
  logic [RD_LAT-1:0]  tagVld_q;
  logic [1:0]         tagRot_q [RD_LAT];
  logic [43:0]        lutR_q, lutL_q, lutU_q, lutD_q;
  logic [35:0]        outPix_q;
  logic               errAddr_q;
  logic [1:0]         issueRot;
  logic               accept;
  logic               anyBad;

  function automatic logic [ADDR_W-1:0] clampAddr(input logic [ADDR_W-1:0] a);
    if (int'(a) >= LUT_DEPTH) return ADDR_W'(LUT_DEPTH - 1);
    return a;
  endfunction

  function automatic logic [43:0] unpackWord(input logic [31:0] w);
    logic [43:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[11*j +: 11] = {{3{w[8*j+7]}}, w[8*j +: 8]};
    return r;
  endfunction

  assign in_ready_o  = (state_q == IDLE) && !rst_i;
  assign accept      = in_valid_i && in_ready_o;
  assign out_valid_o = (state_q == HOLD);

  always_comb begin
    anyBad = 1'b0;
    for (int k = 0; k < 4; k++)
      if (int'(in_addr_i[ADDR_W*k +: ADDR_W]) >= LUT_DEPTH) anyBad = 1'b1;
  end

  // WAIT spans RD_LAT cycles so the last read (ISSUE3) is captured before CALC samples the calculator.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    sram_ren_o = 1'b0;
    issueRot   = 2'd0;
    case (state_q)
      IDLE:   if (accept) state_d = ISSUE0;
      ISSUE0: begin sram_ren_o = 1'b1; issueRot = 2'd0; state_d = ISSUE1; end
      ISSUE1: begin sram_ren_o = 1'b1; issueRot = 2'd1; state_d = ISSUE2; end
      ISSUE2: begin sram_ren_o = 1'b1; issueRot = 2'd2; state_d = ISSUE3; end
      ISSUE3: begin
        sram_ren_o = 1'b1;
        issueRot   = 2'd3;
        state_d    = WAIT;
        waitCnt_d  = CNT_W'(RD_LAT - 1);
      end
      WAIT: begin
        if (waitCnt_q == '0) state_d = CALC;
        else                 waitCnt_d = waitCnt_q - 1'b1;
      end
      CALC:    state_d = HOLD;
      HOLD:    if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      waitCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // R goes straight to the address register; L/U/D wait their turn, already clamped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sramAddr_q <= '0;
      errAddr_q  <= 1'b0;
      for (int k = 0; k < 3; k++) nextAddr_q[k] <= '0;
    end else if (accept) begin
      sramAddr_q <= clampAddr(in_addr_i[ADDR_W-1:0]);
      for (int k = 0; k < 3; k++)
        nextAddr_q[k] <= clampAddr(in_addr_i[ADDR_W*(k+1) +: ADDR_W]);
      if (anyBad) errAddr_q <= 1'b1;
    end else begin
      case (state_q)
        ISSUE0:  sramAddr_q <= nextAddr_q[0];
        ISSUE1:  sramAddr_q <= nextAddr_q[1];
        ISSUE2:  sramAddr_q <= nextAddr_q[2];
        default: sramAddr_q <= sramAddr_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tagVld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) tagRot_q[i] <= '0;
    end else begin
      tagVld_q[0] <= sram_ren_o;
      tagRot_q[0] <= issueRot;
      for (int i = 1; i < RD_LAT; i++) begin
        tagVld_q[i] <= tagVld_q[i-1];
        tagRot_q[i] <= tagRot_q[i-1];
      end
    end
  end

  // Tag at the tail of the pipe marks the cycle its read data is on sram_q_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lutR_q <= '0;
      lutL_q <= '0;
      lutU_q <= '0;
      lutD_q <= '0;
    end else if (tagVld_q[RD_LAT-1]) begin
      case (tagRot_q[RD_LAT-1])
        2'd0:    lutR_q <= unpackWord(sram_q_i);
        2'd1:    lutL_q <= unpackWord(sram_q_i);
        2'd2:    lutU_q <= unpackWord(sram_q_i);
        default: lutD_q <= unpackWord(sram_q_i);
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 outPix_q <= '0;
    else if (state_q == CALC)  outPix_q <= ens_out_i;
  end

`ifdef ROT_ENS_PERF_CNT_EN
  logic [15:0] perfBlocks_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                            perfBlocks_q <= '0;
    else if (out_valid_o && out_ready_i)  perfBlocks_q <= perfBlocks_q + 16'd1;
  end

  assign perf_blocks_o = perfBlocks_q;
`else
  assign perf_blocks_o = 16'd0;
`endif

  assign sram_addr_o = sramAddr_q;
  assign lut_R_o     = lutR_q;
  assign lut_L_o     = lutL_q;
  assign lut_U_o     = lutU_q;
  assign lut_D_o     = lutD_q;
  assign out_pix_o   = outPix_q;
  assign err_addr_o  = errAddr_q;

endmodule

// File: tb/tb_rotational_ensemble_sequencer.sv
// Self-checking bench: SRAM and ensemble-calculator models around the sequencer, results predicted from LUT contents.
module tb_rotational_ensemble_sequencer;

  localparam int LUT_DEPTH = 3392;
  localparam int RD_LAT    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_addr;
  logic        sram_ren;
  logic [11:0] sram_addr;
  logic [31:0] sram_q;
  logic [43:0] lut_R, lut_L, lut_U, lut_D;
  logic [35:0] ens_out;
  logic        out_valid;
  logic        out_ready;
  logic [35:0] out_pix;
  logic        err_addr;
  logic [15:0] perf_blocks;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int blocksDone = 0;
  bit errExp = 1'b0;

  logic [31:0] mem [LUT_DEPTH];
  logic [31:0] rdPipe [RD_LAT];

  rotational_ensemble_sequencer #(.LUT_DEPTH(LUT_DEPTH), .ADDR_W(12), .RD_LAT(RD_LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_addr_i(in_addr),
    .sram_ren_o(sram_ren), .sram_addr_o(sram_addr), .sram_q_i(sram_q),
    .lut_R_o(lut_R), .lut_L_o(lut_L), .lut_U_o(lut_U), .lut_D_o(lut_D),
    .ens_out_i(ens_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_pix_o(out_pix),
    .err_addr_o(err_addr), .perf_blocks_o(perf_blocks)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  // SRAM model: garbage on sram_q whenever no read is in flight.
  always @(posedge clk) begin
    rdPipe[0] <= sram_ren ? mem[sram_addr] : $urandom();
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign sram_q = rdPipe[RD_LAT-1];

  function automatic logic [8:0] sumToPix(input int s);
    if (s < 0) return 9'd16;
    return 9'((s >>> 3) + 16);
  endfunction

  // Ensemble calculator model, combinational on the capture registers.
  always_comb begin
    ens_out = '0;
    for (int j = 0; j < 4; j++)
      ens_out[9*j +: 9] = sumToPix(int'($signed(lut_R[11*j +: 11])) + int'($signed(lut_L[11*j +: 11]))
                                 + int'($signed(lut_U[11*j +: 11])) + int'($signed(lut_D[11*j +: 11])));
  end

  function automatic logic [11:0] clampRef(input logic [11:0] a);
    return (int'(a) >= LUT_DEPTH) ? 12'(LUT_DEPTH - 1) : a;
  endfunction

  function automatic logic [47:0] expIssued(input logic [47:0] addr);
    logic [47:0] r;
    for (int k = 0; k < 4; k++) r[12*k +: 12] = clampRef(addr[12*k +: 12]);
    return r;
  endfunction

  function automatic logic [35:0] expPix(input logic [47:0] addr);
    logic [35:0] r;
    logic [31:0] w [4];
    int s;
    for (int k = 0; k < 4; k++) w[k] = mem[clampRef(addr[12*k +: 12])];
    for (int j = 0; j < 4; j++) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += int'($signed(w[k][8*j +: 8]));
      r[9*j +: 9] = sumToPix(s);
    end
    return r;
  endfunction

  function automatic bit anyOut(input logic [47:0] addr);
    for (int k = 0; k < 4; k++) if (int'(addr[12*k +: 12]) >= LUT_DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] expPerf();
`ifdef ROT_ENS_PERF_CNT_EN
    return 16'(blocksDone);
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [11:0] randAddr();
    if ($urandom_range(0, 7) == 0) return 12'($urandom_range(LUT_DEPTH, 4095));
    return 12'($urandom_range(0, LUT_DEPTH - 1));
  endfunction

  // Runs one block from a negedge in IDLE; returns observations only, callers compare.
  task automatic run_block(input logic [47:0] addr, input int stallCycles, input bit holdValid,
                           output int lat, output logic [35:0] pix, output logic [15:0] renMask,
                           output logic [47:0] issued, output int badReady, output int stallBad,
                           output int acceptCyc);
    int nRen, held;
    bit done;
    lat = -1; pix = '0; renMask = '0; issued = '0;
    badReady = 0; stallBad = 0; nRen = 0; held = 0; done = 1'b0;
    in_valid = 1'b1; in_addr = addr; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    acceptCyc = cycleCnt;
    if (anyOut(addr)) errExp = 1'b1;
    in_valid = holdValid; in_addr = 48'({$urandom(), $urandom()});
    for (int n = 1; n < 60 && !done; n++) begin
      if (sram_ren) begin
        if (n < 16) renMask[n] = 1'b1;
        if (nRen < 4) issued[12*nRen +: 12] = sram_addr;
        nRen++;
      end
      if (in_ready) badReady++;
      if (out_valid) begin
        if (lat < 0) begin lat = n; pix = out_pix; end
        else if (out_pix !== pix || sram_ren) stallBad++;
        if (held >= stallCycles) out_ready = 1'b1;
        held++;
        if (out_ready) done = 1'b1;
      end
      @(negedge clk);
    end
    if (done) blocksDone++;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_addr = '0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_ready); end
    checks++; if (sram_ren !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ren: got %0b expected 0", sram_ren); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_pix !== 36'd0)  begin errors++; $display("[TB] FAIL reset_out_pix: got %0h expected 0", out_pix); end
    checks++; if (err_addr !== 1'b0)  begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err_addr); end
    checks++; if (perf_blocks !== 16'd0) begin errors++; $display("[TB] FAIL reset_perf: got %0d expected 0", perf_blocks); end
    rst = 1'b0;
    blocksDone = 0; errExp = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_in_ready: got %0b expected 1", in_ready); end
  endtask

  task automatic test_directed();
    int lat, br, sb, ac;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    mem[10] = 32'h08080808; mem[20] = 32'h08080808; mem[30] = 32'h08080808; mem[40] = 32'h08080808;
    run_block({12'd40, 12'd30, 12'd20, 12'd10}, 0, 1'b0, lat, pix, rm, iss, br, sb, ac);
    checks++; if (iss !== {12'd40, 12'd30, 12'd20, 12'd10}) begin errors++; $display("[TB] FAIL dir_addrs: got %0h expected %0h", iss, {12'd40, 12'd30, 12'd20, 12'd10}); end
    checks++; if (rm !== 16'b0000_0000_0001_1110) begin errors++; $display("[TB] FAIL dir_ren_cycles: got %b expected 11110", rm); end
    checks++; if (lat != RD_LAT + 6) begin errors++; $display("[TB] FAIL dir_latency: got %0d expected %0d", lat, RD_LAT + 6); end
    checks++; if (pix !== {4{9'd20}}) begin errors++; $display("[TB] FAIL dir_pix: got %0h expected %0h", pix, {4{9'd20}}); end
    checks++; if (br != 0) begin errors++; $display("[TB] FAIL dir_busy_ready: got %0d expected 0", br); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dir_back_idle: got %0b expected 1", in_ready); end
  endtask

  task automatic test_sign();
    int lat, br, sb, ac;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    mem[50] = 32'hF8F8F8F8; mem[51] = 32'hF8F8F8F8; mem[52] = 32'hF8F8F8F8; mem[53] = 32'hF8F8F8F8;
    run_block({12'd53, 12'd52, 12'd51, 12'd50}, 0, 1'b0, lat, pix, rm, iss, br, sb, ac);
    checks++; if (pix !== {4{9'd16}}) begin errors++; $display("[TB] FAIL neg_pix: got %0h expected %0h", pix, {4{9'd16}}); end
  endtask

  task automatic test_distinct();
    int lat, br, sb, ac;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    mem[100] = 32'h00000010; mem[101] = '0; mem[102] = '0; mem[103] = '0;
    run_block({12'd103, 12'd102, 12'd101, 12'd100}, 0, 1'b0, lat, pix, rm, iss, br, sb, ac);
    checks++; if (lut_R[10:0] !== 11'd16) begin errors++; $display("[TB] FAIL distinct_lutR: got %0d expected 16", lut_R[10:0]); end
    checks++; if (lut_L !== 44'd0) begin errors++; $display("[TB] FAIL distinct_lutL: got %0h expected 0", lut_L); end
    checks++; if (pix !== {9'd16, 9'd16, 9'd16, 9'd18}) begin errors++; $display("[TB] FAIL distinct_pix: got %0h expected %0h", pix, {9'd16, 9'd16, 9'd16, 9'd18}); end
  endtask

  task automatic test_stall();
    int lat, br, sb, ac;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    logic [47:0] a;
    a = {12'd7, 12'd300, 12'd2000, 12'd3391};
    run_block(a, 10, 1'b1, lat, pix, rm, iss, br, sb, ac);
    checks++; if (sb != 0) begin errors++; $display("[TB] FAIL stall_stable: got %0d unstable cycles expected 0", sb); end
    checks++; if (br != 0) begin errors++; $display("[TB] FAIL stall_in_ready: got %0d ready cycles expected 0", br); end
    checks++; if (pix !== expPix(a)) begin errors++; $display("[TB] FAIL stall_pix: got %0h expected %0h", pix, expPix(a)); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_release_idle: got %0b expected 1", in_ready); end
  endtask

  task automatic test_err();
    int lat, br, sb, ac;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    logic [47:0] a;
    a = {12'd40, 12'd4000, 12'd20, 12'd10};
    run_block(a, 0, 1'b0, lat, pix, rm, iss, br, sb, ac);
    checks++; if (iss[35:24] !== 12'd3391) begin errors++; $display("[TB] FAIL err_clamp: got %0d expected 3391", iss[35:24]); end
    checks++; if (err_addr !== 1'b1) begin errors++; $display("[TB] FAIL err_set: got %0b expected 1", err_addr); end
    checks++; if (pix !== expPix(a)) begin errors++; $display("[TB] FAIL err_pix: got %0h expected %0h", pix, expPix(a)); end
    run_block({12'd1, 12'd2, 12'd3, 12'd4}, 0, 1'b0, lat, pix, rm, iss, br, sb, ac);
    checks++; if (err_addr !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %0b expected 1", err_addr); end
  endtask

  task automatic test_back_to_back();
    int lat, br, sb, ac0, ac1, ac2;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    logic [47:0] a;
    run_block({randAddr(), randAddr(), randAddr(), randAddr()}, 0, 1'b0, lat, pix, rm, iss, br, sb, ac0);
    run_block({randAddr(), randAddr(), randAddr(), randAddr()}, 0, 1'b0, lat, pix, rm, iss, br, sb, ac1);
    a = {12'd900, 12'd901, 12'd902, 12'd903};
    run_block(a, 0, 1'b0, lat, pix, rm, iss, br, sb, ac2);
    checks++; if (ac1 - ac0 != RD_LAT + 7) begin errors++; $display("[TB] FAIL b2b_period1: got %0d expected %0d", ac1 - ac0, RD_LAT + 7); end
    checks++; if (ac2 - ac1 != RD_LAT + 7) begin errors++; $display("[TB] FAIL b2b_period2: got %0d expected %0d", ac2 - ac1, RD_LAT + 7); end
    checks++; if (pix !== expPix(a)) begin errors++; $display("[TB] FAIL b2b_pix: got %0h expected %0h", pix, expPix(a)); end
  endtask

  task automatic test_midop_reset();
    int lat, br, sb, ac;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    logic [47:0] a;
    mem[200] = 32'h01020304; mem[201] = 32'h7F7F7F7F;
    in_valid = 1'b1; in_addr = {12'd203, 12'd202, 12'd201, 12'd200};
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (sram_ren !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ctrl: got ren=%0b rdy=%0b vld=%0b expected 0 0 0", sram_ren, in_ready, out_valid); end
    checks++; if (sram_addr !== 12'd0) begin errors++; $display("[TB] FAIL midrst_addr: got %0d expected 0", sram_addr); end
    checks++; if (lut_R !== 44'd0 || err_addr !== 1'b0) begin errors++; $display("[TB] FAIL midrst_regs: got lutR=%0h err=%0b expected 0 0", lut_R, err_addr); end
    @(negedge clk);
    rst = 1'b0; blocksDone = 0; errExp = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (lut_L !== 44'd0 || lut_U !== 44'd0) begin errors++; $display("[TB] FAIL midrst_stale: got lutL=%0h lutU=%0h expected 0 0", lut_L, lut_U); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle: got %0b expected 1", in_ready); end
    a = {12'd203, 12'd202, 12'd201, 12'd200};
    run_block(a, 0, 1'b0, lat, pix, rm, iss, br, sb, ac);
    checks++; if (pix !== expPix(a)) begin errors++; $display("[TB] FAIL midrst_next_pix: got %0h expected %0h", pix, expPix(a)); end
    checks++; if (perf_blocks !== expPerf()) begin errors++; $display("[TB] FAIL midrst_perf: got %0d expected %0d", perf_blocks, expPerf()); end
  endtask

  task automatic test_random();
    int lat, br, sb, ac;
    logic [35:0] pix;
    logic [15:0] rm;
    logic [47:0] iss;
    logic [47:0] a;
    for (int t = 0; t < 25; t++) begin
      a = {randAddr(), randAddr(), randAddr(), randAddr()};
      run_block(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), lat, pix, rm, iss, br, sb, ac);
      checks++; if (pix !== expPix(a)) begin errors++; $display("[TB] FAIL rnd_pix[%0d]: got %0h expected %0h", t, pix, expPix(a)); end
      checks++; if (iss !== expIssued(a)) begin errors++; $display("[TB] FAIL rnd_addrs[%0d]: got %0h expected %0h", t, iss, expIssued(a)); end
      checks++; if (lat != RD_LAT + 6 || sb != 0 || br != 0) begin errors++; $display("[TB] FAIL rnd_timing[%0d]: got lat=%0d unstable=%0d busyrdy=%0d expected %0d 0 0", t, lat, sb, br, RD_LAT + 6); end
      checks++; if (err_addr !== errExp) begin errors++; $display("[TB] FAIL rnd_err[%0d]: got %0b expected %0b", t, err_addr, errExp); end
    end
  endtask

  task automatic test_perf();
    checks++; if (perf_blocks !== expPerf()) begin errors++; $display("[TB] FAIL perf_blocks: got %0d expected %0d", perf_blocks, expPerf()); end
  endtask

  initial begin
    for (int i = 0; i < LUT_DEPTH; i++) mem[i] = $urandom();
    test_reset();
    test_directed();
    test_sign();
    test_distinct();
    test_stall();
    test_err();
    test_back_to_back();
    test_midop_reset();
    test_random();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
